// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory stage: funct3 codes, FSM states
// and the store strobe / lane replication helpers.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  // Legal width code and naturally aligned address for this memory op.
  // Unsigned widths only exist for loads.
  function automatic logic op_ok(input logic is_store, input logic [2:0] f3,
                                 input logic [1:0] lane);
    logic ok;
    ok = 1'b0;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = !lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = !is_store;
      F3_HU:   ok = !is_store && !lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Byte write strobes for a store of the given width at the given lane.
  function automatic logic [3:0] store_strobe(input logic [1:0] f3w,
                                              input logic [1:0] lane);
    logic [3:0] we;
    case (f3w)
      2'b00:   we = 4'b0001 << lane;
      2'b01:   we = 4'b0011 << lane;
      default: we = 4'b1111;
    endcase
    return we;
  endfunction

  // Store data replicated across every lane so the strobes pick the bytes.
  function automatic logic [31:0] store_lanes(input logic [1:0] f3w,
                                              input logic [31:0] d);
    logic [31:0] w;
    case (f3w)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Load lane extraction: picks the byte/half addressed by lane out of the
// RAM word and sign- or zero-extends it according to funct3.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] value
);

  logic [7:0]  sel_b;
  logic [15:0] sel_h;

  // Select the addressed byte and half, then extend to 32 bits.
  always_comb begin
    sel_b = rdata[7:0];
    case (lane)
      2'd0: sel_b = rdata[7:0];
      2'd1: sel_b = rdata[15:8];
      2'd2: sel_b = rdata[23:16];
      2'd3: sel_b = rdata[31:24];
      default: sel_b = rdata[7:0];
    endcase
    sel_h = lane[1] ? rdata[31:16] : rdata[15:0];
    case (funct3)
      F3_B:    value = {{24{sel_b[7]}}, sel_b};
      F3_H:    value = {{16{sel_h[15]}}, sel_h};
      F3_BU:   value = {24'h0, sel_b};
      F3_HU:   value = {16'h0, sel_h};
      default: value = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Data-memory pipeline stage. Accepts one op per cycle while not waiting on
// RAM; memory ops hold a request on the RAM port until mem_ready, everything
// else (ALU passthrough, faults) completes one cycle after accept.
//
// Handshake: an op is taken on any rising edge with enabled=1 and the FSM
// not in ACCESS (stall=0 seen in the previous cycle); a RAM request is
// mem_en=1 with address/strobes/data held constant, and it completes on the
// rising edge where mem_en=1 and mem_ready=1. Dropping mem_en without
// mem_ready (only on reset) cancels the request.
module mem_access
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH = 15
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  enabled,
  input  logic                  is_load,
  input  logic                  is_store,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [31:0]           alu_result,
  input  logic [31:0]           store_data,
  input  logic [4:0]            rd_addr,
  output logic                  stall,
  output logic                  completed,
  output logic                  wb_valid,
  output logic [4:0]            rd_out,
  output logic [31:0]           data_out,
  output logic                  fault,
  output logic                  mem_en,
  output logic [3:0]            mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata,
  input  logic                  mem_ready,
  output state_t                state_dbg
);

  state_t      state;
  logic [2:0]  op_f3;
  logic [1:0]  op_lane;
  logic [4:0]  op_rd;
  logic        op_load;
  logic [31:0] load_value;
  logic        accept;
  logic        mem_op;
  logic        legal;
  logic        unused_addr_bits;

  assign accept    = enabled && (state != ACCESS);
  assign mem_op    = is_load || is_store;
  assign legal     = op_ok(is_store, funct3, addr[1:0]);
  assign state_dbg = state;

  // Address bits above the RAM window wrap around silently.
  assign unused_addr_bits = ^addr[31:ADDR_WIDTH+2];

  load_align u_load_align (
    .rdata  (mem_rdata),
    .lane   (op_lane),
    .funct3 (op_f3),
    .value  (load_value)
  );

  // Stage FSM with all outputs registered; completed/wb_valid/fault pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      op_f3     <= 3'b0;
      op_lane   <= 2'b0;
      op_rd     <= 5'b0;
      op_load   <= 1'b0;
      stall     <= 1'b0;
      completed <= 1'b0;
      wb_valid  <= 1'b0;
      fault     <= 1'b0;
      rd_out    <= 5'b0;
      data_out  <= 32'h0;
      mem_en    <= 1'b0;
      mem_we    <= 4'b0;
      mem_addr  <= '0;
      mem_wdata <= 32'h0;
    end else begin
      completed <= 1'b0;
      wb_valid  <= 1'b0;
      fault     <= 1'b0;
      case (state)
        ACCESS: begin
          if (mem_ready) begin
            state     <= RESP;
            mem_en    <= 1'b0;
            mem_we    <= 4'b0;
            stall     <= 1'b0;
            completed <= 1'b1;
            rd_out    <= op_rd;
            wb_valid  <= op_load && (op_rd != 5'd0);
            data_out  <= op_load ? load_value : 32'h0;
          end
        end
        default: begin
          if (accept) begin
            op_f3   <= funct3;
            op_lane <= addr[1:0];
            op_rd   <= rd_addr;
            op_load <= is_load && !is_store;
            rd_out  <= rd_addr;
            if (!mem_op) begin
              state     <= RESP;
              completed <= 1'b1;
              data_out  <= alu_result;
              wb_valid  <= (rd_addr != 5'd0);
            end else if (!legal) begin
              state     <= RESP;
              completed <= 1'b1;
              fault     <= 1'b1;
              data_out  <= 32'h0;
            end else begin
              state     <= ACCESS;
              mem_en    <= 1'b1;
              stall     <= 1'b1;
              mem_addr  <= addr[ADDR_WIDTH+1:2];
              mem_we    <= is_store ? store_strobe(funct3[1:0], addr[1:0]) : 4'b0;
              mem_wdata <= is_store ? store_lanes(funct3[1:0], store_data) : 32'h0;
            end
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Bench for mem_access: directed ops, a RAM responder that checks every
// request against an expected queue, and a completion monitor that checks
// write-back results against a second expected queue.
module tb_mem_access;
  import mem_pkg::*;

  typedef struct packed {
    logic        wb;
    logic [4:0]  rd;
    logic [31:0] data;
    logic        chk_data;
    logic        flt;
    logic        b2b;
  } exp_t;

  typedef struct packed {
    logic [3:0]  we;
    logic [14:0] addr;
    logic [31:0] wdata;
    logic        chk_wdata;
    logic [7:0]  stall_n;
  } req_t;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        enabled = 1'b0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic [2:0]  funct3 = 3'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] alu_result = 32'h0;
  logic [31:0] store_data = 32'h0;
  logic [4:0]  rd_addr = 5'd0;
  logic        stall, completed, wb_valid, fault, mem_en;
  logic [4:0]  rd_out;
  logic [31:0] data_out, mem_wdata;
  logic [3:0]  mem_we;
  logic [14:0] mem_addr;
  logic [31:0] mem_rdata = 32'h0;
  logic        mem_ready = 1'b0;
  state_t      state_dbg;

  exp_t exp_q[$];
  req_t req_q[$];
  int checks = 0;
  int failures = 0;
  int cycle = 0;
  int last_done = -10;
  int ram_wait = 0;
  int ram_cnt = 0;
  int acc_cycles = 0;
  logic [31:0] ram_rdata = 32'h0;

  mem_access #(.ADDR_WIDTH(15)) dut (
    .clk(clk), .rstn(rstn), .enabled(enabled), .is_load(is_load),
    .is_store(is_store), .funct3(funct3), .addr(addr),
    .alu_result(alu_result), .store_data(store_data), .rd_addr(rd_addr),
    .stall(stall), .completed(completed), .wb_valid(wb_valid),
    .rd_out(rd_out), .data_out(data_out), .fault(fault), .mem_en(mem_en),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  function automatic exp_t mk_exp(input logic wb, input logic [4:0] rd,
                                  input logic [31:0] data, input logic chk_data,
                                  input logic flt, input logic b2b);
    exp_t e;
    e.wb = wb; e.rd = rd; e.data = data; e.chk_data = chk_data;
    e.flt = flt; e.b2b = b2b;
    return e;
  endfunction

  function automatic req_t mk_req(input logic [3:0] we, input logic [14:0] a,
                                  input logic [31:0] wdata, input logic chk_wdata,
                                  input int wait_n);
    req_t r;
    r.we = we; r.addr = a; r.wdata = wdata; r.chk_wdata = chk_wdata;
    r.stall_n = 8'(wait_n + 1);
    return r;
  endfunction

  // driver: called on a falling edge, returns on a later falling edge
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] alu,
                       input logic [31:0] sd, input logic [4:0] rd,
                       input int wait_n, input logic [31:0] rdata,
                       input exp_t e, input logic has_req, input req_t r);
    int n;
    n = 0;
    while (stall && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (stall) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout actual=stall required=idle");
    end
    ram_wait  = wait_n;
    ram_rdata = rdata;
    if (has_req) req_q.push_back(r);
    exp_q.push_back(e);
    is_load = ld; is_store = st; funct3 = f3; addr = a;
    alu_result = alu; store_data = sd; rd_addr = rd;
    enabled = 1'b1;
    @(negedge clk);
    enabled = 1'b0;
  endtask

  // RAM responder: checks each request cycle, raises mem_ready after ram_wait
  always @(negedge clk) begin
    if (!rstn) begin
      mem_ready = 1'b0;
      ram_cnt = 0;
      acc_cycles = 0;
    end else if (mem_en) begin
      acc_cycles++;
      chk("stall_in_access", {31'b0, stall}, 32'd1);
      if (req_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_mem_en actual=addr_0x%04h required=no_request", mem_addr);
      end else begin
        chk("mem_addr", {17'b0, mem_addr}, {17'b0, req_q[0].addr});
        chk("mem_we", {28'b0, mem_we}, {28'b0, req_q[0].we});
        if (req_q[0].chk_wdata) chk("mem_wdata", mem_wdata, req_q[0].wdata);
      end
      if (ram_cnt >= ram_wait) begin
        mem_ready = 1'b1;
        mem_rdata = ram_rdata;
        if (req_q.size() != 0) begin
          chk("stall_cycles", acc_cycles, {24'b0, req_q[0].stall_n});
          void'(req_q.pop_front());
        end
        ram_cnt = 0;
        acc_cycles = 0;
      end else begin
        mem_ready = 1'b0;
        ram_cnt++;
      end
    end else begin
      mem_ready = 1'b0;
      ram_cnt = 0;
      acc_cycles = 0;
      if (stall) begin
        checks++;
        failures++;
        $display("FAIL stall_without_mem_en actual=1 required=0");
      end
    end
  end

  // completion monitor
  always @(negedge clk) begin
    if (rstn && completed) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_completed actual=rd%0d required=none", rd_out);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("wb_valid", {31'b0, wb_valid}, {31'b0, e.wb});
        chk("rd_out", {27'b0, rd_out}, {27'b0, e.rd});
        chk("fault", {31'b0, fault}, {31'b0, e.flt});
        if (e.chk_data) chk("data_out", data_out, e.data);
        if (e.b2b) chk("back_to_back_gap", cycle - last_done, 32'd1);
      end
      last_done = cycle;
    end
  end

  // an op must never be offered while a RAM access is outstanding
  always @(posedge clk) begin
    if (rstn && enabled) begin
      checks++;
      if (state_dbg == ACCESS) begin
        failures++;
        $display("FAIL enabled_in_access actual=ACCESS required=IDLE_or_RESP");
      end
    end
  end

  localparam req_t NO_REQ = '0;

  initial begin
    int n;
    // reset state
    #12;
    chk("reset_mem_en", {31'b0, mem_en}, 32'd0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_completed", {31'b0, completed}, 32'd0);
    chk("reset_data_out", data_out, 32'd0);
    chk("reset_state", {30'b0, state_dbg}, {30'b0, IDLE});
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);

    // ALU passthrough
    issue(0, 0, F3_W, 32'h0, 32'h12345678, 32'h0, 5'd5, 0, 32'h0,
          mk_exp(1, 5'd5, 32'h12345678, 1, 0, 0), 0, NO_REQ);
    // SB at lane 3, then LB / LBU of the same byte
    issue(0, 1, F3_B, 32'h103, 32'h0, 32'h000000AB, 5'd1, 0, 32'h0,
          mk_exp(0, 5'd1, 32'h0, 0, 0, 0), 1, mk_req(4'b1000, 15'h40, 32'hABABABAB, 1, 0));
    issue(1, 0, F3_B, 32'h103, 32'h0, 32'h0, 5'd6, 1, 32'hAB000000,
          mk_exp(1, 5'd6, 32'hFFFFFFAB, 1, 0, 0), 1, mk_req(4'b0000, 15'h40, 32'h0, 0, 1));
    issue(1, 0, F3_BU, 32'h103, 32'h0, 32'h0, 5'd7, 0, 32'hAB000000,
          mk_exp(1, 5'd7, 32'h000000AB, 1, 0, 0), 1, mk_req(4'b0000, 15'h40, 32'h0, 0, 0));
    // LW with three wait states
    issue(1, 0, F3_W, 32'h8, 32'h0, 32'h0, 5'd8, 3, 32'hDEADBEEF,
          mk_exp(1, 5'd8, 32'hDEADBEEF, 1, 0, 0), 1, mk_req(4'b0000, 15'h2, 32'h0, 0, 3));
    // faults: misaligned LH, illegal load funct3, unsigned store code
    issue(1, 0, F3_H, 32'h101, 32'h0, 32'h0, 5'd4, 0, 32'h0,
          mk_exp(0, 5'd4, 32'h0, 0, 1, 0), 0, NO_REQ);
    issue(1, 0, 3'b011, 32'h0, 32'h0, 32'h0, 5'd9, 0, 32'h0,
          mk_exp(0, 5'd9, 32'h0, 0, 1, 0), 0, NO_REQ);
    issue(0, 1, F3_BU, 32'h0, 32'h0, 32'h55, 5'd2, 0, 32'h0,
          mk_exp(0, 5'd2, 32'h0, 0, 1, 0), 0, NO_REQ);
    // SW followed by an ALU op in its RESP cycle
    issue(0, 1, F3_W, 32'h10, 32'h0, 32'hCAFEF00D, 5'd0, 0, 32'h0,
          mk_exp(0, 5'd0, 32'h0, 0, 0, 0), 1, mk_req(4'b1111, 15'h4, 32'hCAFEF00D, 1, 0));
    issue(0, 0, F3_W, 32'h0, 32'h00000055, 32'h0, 5'd3, 0, 32'h0,
          mk_exp(1, 5'd3, 32'h00000055, 1, 0, 1), 0, NO_REQ);
    // load to x0 still reads RAM
    issue(1, 0, F3_W, 32'h20, 32'h0, 32'h0, 5'd0, 0, 32'h11111111,
          mk_exp(0, 5'd0, 32'h0, 0, 0, 0), 1, mk_req(4'b0000, 15'h8, 32'h0, 0, 0));
    // SH upper half, then LH / LHU
    issue(0, 1, F3_H, 32'h2, 32'h0, 32'h1234BEEF, 5'd0, 0, 32'h0,
          mk_exp(0, 5'd0, 32'h0, 0, 0, 0), 1, mk_req(4'b1100, 15'h0, 32'hBEEFBEEF, 1, 0));
    issue(1, 0, F3_H, 32'h2, 32'h0, 32'h0, 5'd11, 2, 32'h80010000,
          mk_exp(1, 5'd11, 32'hFFFF8001, 1, 0, 0), 1, mk_req(4'b0000, 15'h0, 32'h0, 0, 2));
    issue(1, 0, F3_HU, 32'h2, 32'h0, 32'h0, 5'd12, 0, 32'h80010000,
          mk_exp(1, 5'd12, 32'h00008001, 1, 0, 0), 1, mk_req(4'b0000, 15'h0, 32'h0, 0, 0));
    // ALU to x0, high address wrap
    issue(0, 0, F3_W, 32'h0, 32'h77777777, 32'h0, 5'd0, 0, 32'h0,
          mk_exp(0, 5'd0, 32'h0, 0, 0, 0), 0, NO_REQ);
    issue(1, 0, F3_W, 32'hFFFF0004, 32'h0, 32'h0, 5'd10, 1, 32'h0BADF00D,
          mk_exp(1, 5'd10, 32'h0BADF00D, 1, 0, 0), 1, mk_req(4'b0000, 15'h4001, 32'h0, 0, 1));

    // reset while a request is stuck in ACCESS
    issue(1, 0, F3_W, 32'h40, 32'h0, 32'h0, 5'd13, 50, 32'h0,
          mk_exp(1, 5'd13, 32'h0, 0, 0, 0), 1, mk_req(4'b0000, 15'h10, 32'h0, 0, 50));
    @(negedge clk);
    chk("pre_reset_mem_en", {31'b0, mem_en}, 32'd1);
    #2 rstn = 1'b0;
    #1;
    chk("async_reset_mem_en", {31'b0, mem_en}, 32'd0);
    chk("async_reset_stall", {31'b0, stall}, 32'd0);
    chk("async_reset_completed", {31'b0, completed}, 32'd0);
    chk("async_reset_state", {30'b0, state_dbg}, {30'b0, IDLE});
    exp_q.delete();
    req_q.delete();
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    issue(1, 0, F3_W, 32'h44, 32'h0, 32'h0, 5'd14, 0, 32'h600DCAFE,
          mk_exp(1, 5'd14, 32'h600DCAFE, 1, 0, 0), 1, mk_req(4'b0000, 15'h11, 32'h0, 0, 0));

    // drain
    n = 0;
    while ((exp_q.size() != 0 || req_q.size() != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 32'd0);
    chk("req_q_drained", req_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
